// File: rtl/mmio_button_ctrl_if.sv
// Processor data-port signals seen by the button/output MMIO peripheral.
// The master side is the processor; the slave side is the peripheral.
interface mmio_button_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic        rd_hit;
  logic [31:0] rd_data;

  modport master (
    output mem_addr, mem_wren, mem_wdata,
    input  rd_hit, rd_data
  );

  modport slave (
    input  mem_addr, mem_wren, mem_wdata,
    output rd_hit, rd_data
  );
endinterface

// File: rtl/mmio_button_ctrl.sv
// Button synchroniser/debouncer with sticky read-to-clear events and a persistent output register.
// Optional feature macro MMIO_IRQ_EN: adds an IRQ mask register at OUT_ADDR+4 and drives irq.
module mmio_button_ctrl #(
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_W           = 20,
  parameter logic [31:0] BTN_BASE        = 32'd3000,
  parameter logic [31:0] BTN_STRIDE      = 32'd1000,
  parameter logic [31:0] OUT_ADDR        = 32'd2000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_raw,
  mmio_button_ctrl_if.slave   bus,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [31:0]         out_data,
  output logic                out_strobe,
  output logic                irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] event_q, event_d;
  logic               rd_hit_q, rd_hit_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_strobe_q, out_strobe_d;
  logic [NUM_BTN-1:0] rd_sel;
  logic               out_wr;
`ifdef MMIO_IRQ_EN
  logic [NUM_BTN-1:0] mask_q, mask_d;
  logic               mask_wr, mask_rd;
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    // A single matching sample drops the count back to zero, so only a full stable run toggles.
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) level_d[i] = ~level_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    rd_sel = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!bus.mem_wren && (bus.mem_addr == BTN_BASE + BTN_STRIDE * 32'(i))) rd_sel[i] = 1'b1;
    end

    rd_hit_d  = |rd_sel;
    rd_data_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rd_sel[i]) rd_data_d = {30'b0, event_q[i], level_q[i]};
    end

    // Rising edge is ORed in after the read-clear so a coincident press is never lost.
    event_d = (event_q & ~rd_sel) | (level_d & ~level_q);

    out_wr       = bus.mem_wren && (bus.mem_addr == OUT_ADDR);
    out_data_d   = out_wr ? bus.mem_wdata : out_data_q;
    out_strobe_d = out_wr;

`ifdef MMIO_IRQ_EN
    mask_wr = bus.mem_wren && (bus.mem_addr == OUT_ADDR + 32'd4);
    mask_rd = !bus.mem_wren && (bus.mem_addr == OUT_ADDR + 32'd4);
    mask_d  = mask_wr ? bus.mem_wdata[NUM_BTN-1:0] : mask_q;
    if (mask_rd) begin
      rd_hit_d  = 1'b1;
      rd_data_d = {{(32-NUM_BTN){1'b0}}, mask_q};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      level_q      <= '0;
      event_q      <= '0;
      rd_hit_q     <= 1'b0;
      rd_data_q    <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
`ifdef MMIO_IRQ_EN
      mask_q       <= '1;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      level_q      <= level_d;
      event_q      <= event_d;
      rd_hit_q     <= rd_hit_d;
      rd_data_q    <= rd_data_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
`ifdef MMIO_IRQ_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign bus.rd_hit  = rd_hit_q;
  assign bus.rd_data = rd_data_q;
  assign btn_level   = level_q;
  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
`ifdef MMIO_IRQ_EN
  assign irq = |(event_q & mask_q);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Directed bench for mmio_button_ctrl with a short debounce window (DEBOUNCE_CYCLES=4).
// Expected irq follows MMIO_IRQ_EN: tied low when the macro is undefined.
module tb_mmio_button_ctrl;

`ifdef MMIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [31:0] out_data;
  logic       out_strobe;
  logic       irq;

  int checks = 0;
  int errors = 0;

  mmio_button_ctrl_if bus ();

  mmio_button_ctrl #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .bus        (bus),
    .btn_level  (btn_level),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_addr = a;
    bus.mem_wren = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr  = a;
    bus.mem_wren  = 1'b1;
    bus.mem_wdata = d;
    tick(1);
  endtask

  task automatic idle();
    bus.mem_addr  = 32'd0;
    bus.mem_wren  = 1'b0;
    bus.mem_wdata = 32'd0;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 5'h1F;
    idle();
    #2 reset = 1'b0;
    tick(3);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_rd_hit", 32'(bus.rd_hit), 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_strobe", 32'(out_strobe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Release: all buttons held, levels rise on the 6th edge
    reset = 1'b1;
    tick(5);
    check("rel_level_e5", 32'(btn_level), 32'h0);
    tick(1);
    check("rel_level_e6", 32'(btn_level), 32'h1F);
    check("rel_irq", 32'(irq), 32'(IRQ_ON));
    for (int i = 0; i < 5; i++) begin
      rd(32'd3000 + 32'd1000 * 32'(i));
      check("rel_rd_hit", 32'(bus.rd_hit), 32'h1);
      check("rel_rd_data", bus.rd_data, 32'h3);
    end
    idle();
    check("rel_irq_clr", 32'(irq), 32'h0);

    // Releasing the buttons must not create events
    btn_raw = 5'h00;
    tick(6);
    check("fall_level", 32'(btn_level), 32'h0);
    check("fall_irq", 32'(irq), 32'h0);
    rd(32'd3000);
    check("fall_rd_data", bus.rd_data, 32'h0);
    idle();

    // Bounce on channel 0, then a stable press
    for (int c = 0; c < 20; c++) begin
      btn_raw[0] = ((c / 2) % 2 == 0);
      tick(1);
      check("bounce_level", 32'(btn_level[0]), 32'h0);
    end
    btn_raw[0] = 1'b1;
    tick(5);
    check("bounce_e5", 32'(btn_level[0]), 32'h0);
    tick(1);
    check("bounce_e6", 32'(btn_level[0]), 32'h1);
    check("bounce_irq", 32'(irq), 32'(IRQ_ON));

    // Read-clear on channel 2
    btn_raw[2] = 1'b1;
    tick(6);
    check("rc_level", 32'(btn_level), 32'h05);
    rd(32'd5000);
    check("rc_hit", 32'(bus.rd_hit), 32'h1);
    check("rc_first", bus.rd_data, 32'h3);
    rd(32'd5000);
    check("rc_second", bus.rd_data, 32'h1);
    idle();
    tick(1);
    check("rc_idle_hit", 32'(bus.rd_hit), 32'h0);
    check("rc_idle_data", bus.rd_data, 32'h0);
    rd(32'd3000);
    check("rc_ch0", bus.rd_data, 32'h3);
    idle();
    check("rc_irq", 32'(irq), 32'h0);

    // Collision: channel 1 debounces on the same edge as its read
    btn_raw[1] = 1'b1;
    tick(5);
    check("col_pre_level", 32'(btn_level), 32'h05);
    rd(32'd4000);
    check("col_hit", 32'(bus.rd_hit), 32'h1);
    check("col_data", bus.rd_data, 32'h0);
    check("col_level", 32'(btn_level), 32'h07);
    check("col_irq", 32'(irq), 32'(IRQ_ON));
    idle();
    tick(1);
    rd(32'd4000);
    check("col_event_kept", bus.rd_data, 32'h3);
    idle();

    // Output register
    wr(32'd2000, 32'hDEADBEEF);
    check("out_data", out_data, 32'hDEADBEEF);
    check("out_strobe", 32'(out_strobe), 32'h1);
    check("out_rd_hit", 32'(bus.rd_hit), 32'h0);
    wr(32'd2001, 32'h12345678);
    check("out_hold_2001", out_data, 32'hDEADBEEF);
    check("out_strobe_off", 32'(out_strobe), 32'h0);
    wr(32'd0, 32'h0BADF00D);
    check("out_hold_0", out_data, 32'hDEADBEEF);
    wr(32'd3000, 32'hFFFFFFFF);
    check("out_wr_chan_hit", 32'(bus.rd_hit), 32'h0);
    check("out_hold_chan", out_data, 32'hDEADBEEF);
    wr(32'd2000, 32'h11111111);
    wr(32'd2000, 32'h22222222);
    check("b2b_data", out_data, 32'h22222222);
    check("b2b_strobe", 32'(out_strobe), 32'h1);
    idle();
    tick(1);
    check("b2b_strobe_end", 32'(out_strobe), 32'h0);
    check("b2b_hold", out_data, 32'h22222222);

    rd(32'd2004);
    check("mask_rd_hit", 32'(bus.rd_hit), 32'(IRQ_ON));
    check("mask_rd_data", bus.rd_data, IRQ_ON ? 32'h1F : 32'h0);
    idle();

    // Reset mid-operation: event pending on ch3, ch4 part-way through debounce
    btn_raw[3] = 1'b1;
    tick(6);
    check("mid_level", 32'(btn_level), 32'h0F);
    check("mid_irq", 32'(irq), 32'(IRQ_ON));
    btn_raw[4] = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check("mid_rst_level", 32'(btn_level), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_out", out_data, 32'h0);
    check("mid_rst_strobe", 32'(out_strobe), 32'h0);
    check("mid_rst_rd_hit", 32'(bus.rd_hit), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("mid_restart_e5", 32'(btn_level), 32'h0);
    tick(1);
    check("mid_restart_e6", 32'(btn_level), 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
